md_unit: RTL and testbench

- Parametrised iterative multiply/divide execute unit for the RV32M/RV64M extension. It is the next generation of the ALU decode path.
- It decodes M-extension R-type instructions (ALUOp=10, Funct7=0000001) from the same ALUOp/Funct7/Funct3 fields the ALU controller consumes.
- It runs a radix-2 shift-add multiply or restoring divide, one bit per cycle.
- Sits in EX beside the ALU. Holds the pipeline through `stall` while busy.

---
 rtl/md_unit_if.sv | 27 ++
 rtl/md_unit.sv | 189 ++++++++++++++++++
 tb/tb_md_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// EX-stage request/response bundle for the iterative multiply/divide unit.
// The pipeline drives the decode fields and operands; the unit returns select, stall, done and result.
interface md_unit_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            md_sel;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output valid, ALUOp, Funct7, Funct3, flush, op_a, op_b,
    input  md_sel, stall, done, result
  );

  modport slave (
    input  valid, ALUOp, Funct7, Funct3, flush, op_a, op_b,
    output md_sel, stall, done, result
  );
endinterface

// File: rtl/md_unit.sv
// Iterative RV32M/RV64M execute unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, holding the pipeline through stall until the one-cycle done pulse.
module md_unit #(
  parameter int XLEN           = 32,
  parameter bit SPECIAL_BYPASS = 1'b1
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave bus
);

  localparam int              CW   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        op;
  logic              neg_q;
  logic              neg_r;
  logic              div0;
  logic              ovf;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   a_raw;
  logic [XLEN-1:0]   result_r;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     counter;
  logic              done_r;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Decode and operand conditioning (combinational, before the accept edge)
  logic            md_sel_w;
  logic            stall_w;
  logic            accept;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic            in_div0;
  logic            in_ovf;
  logic            bypass;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign md_sel_w = bus.valid && (bus.ALUOp == 2'b10) && (bus.Funct7 == 7'b0000001);
  assign is_div   = bus.Funct3[2];
  // MULHSU is the only op with mixed signedness: op_a signed, op_b unsigned.
  assign a_signed = is_div ? !bus.Funct3[0] : (bus.Funct3[1:0] != 2'b11);
  assign b_signed = is_div ? !bus.Funct3[0] : !bus.Funct3[1];
  assign sa       = a_signed && bus.op_a[XLEN-1];
  assign sb       = b_signed && bus.op_b[XLEN-1];
  assign a_mag    = neg_if(bus.op_a, sa);
  assign b_mag    = neg_if(bus.op_b, sb);
  assign in_div0  = is_div && (bus.op_b == '0);
  assign in_ovf   = is_div && !bus.Funct3[0] && (bus.op_a == SMIN) && (bus.op_b == '1);
  assign bypass   = SPECIAL_BYPASS && (in_div0 || in_ovf);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // done_r masks the held instruction in the done cycle so it is neither stalled nor re-accepted.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    stall_w   = 1'b0;
    unique case (state)
      IDLE: begin
        stall_w = md_sel_w && !done_r;
        if (md_sel_w && !done_r && !bus.flush) begin
          accept    = 1'b1;
          state_nxt = bypass ? DONE : CALC;
        end
      end
      CALC: begin
        stall_w = 1'b1;
        if (bus.flush)            state_nxt = IDLE;
        else if (counter == '0)   state_nxt = DONE;
      end
      DONE: begin
        stall_w   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration step datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign div_shift = {remainder, quotient[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[XLEN-1:0] - opnd;

  // Sign fix, special-case override and result select (DONE stage)
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   res_nxt;

  always_comb begin
    prod  = neg_if2(acc, neg_q);
    q_fix = neg_if(quotient, neg_q);
    r_fix = neg_if(remainder, neg_r);
    if (div0) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = a_raw;
      r_fix = '0;
    end
    case (op)
      3'b000:                res_nxt = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_nxt = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        res_nxt = q_fix;
      default:               res_nxt = r_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
      opnd      <= '0;
      quotient  <= '0;
      remainder <= '0;
      a_raw     <= '0;
      acc       <= '0;
      counter   <= '0;
      result_r  <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        op        <= bus.Funct3;
        neg_q     <= sa ^ sb;
        neg_r     <= sa;
        div0      <= in_div0;
        ovf       <= in_ovf;
        a_raw     <= bus.op_a;
        opnd      <= is_div ? b_mag : a_mag;
        acc       <= {{XLEN{1'b0}}, b_mag};
        quotient  <= a_mag;
        remainder <= '0;
        counter   <= CW'(XLEN);
      end else if (state == CALC && !bus.flush && counter != '0) begin
        counter <= counter - CW'(1);
        if (op[2]) begin
          remainder <= div_ge ? div_diff : div_shift[XLEN-1:0];
          quotient  <= {quotient[XLEN-2:0], div_ge};
        end else begin
          acc <= {mul_sum, acc[XLEN-1:1]};
        end
      end else if (state == DONE && !bus.flush) begin
        result_r <= res_nxt;
        done_r   <= 1'b1;
      end
    end
  end

  assign bus.md_sel = md_sel_w;
  assign bus.stall  = stall_w;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: two instances (special-case bypass on and off) driven in lockstep,
// compared against an arithmetic reference model and a table of known answers.
module tb_md_unit;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if #(.XLEN(XLEN)) b0 ();
  md_unit_if #(.XLEN(XLEN)) b1 ();

  md_unit #(.XLEN(XLEN), .SPECIAL_BYPASS(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  md_unit #(.XLEN(XLEN), .SPECIAL_BYPASS(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_exp;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          sp;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] aluop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    b0.valid = v; b0.ALUOp = aluop; b0.Funct7 = f7; b0.Funct3 = f3; b0.op_a = a; b0.op_b = b;
    b1.valid = v; b1.ALUOp = aluop; b1.Funct7 = f7; b1.Funct3 = f3; b1.op_a = a; b1.op_b = b;
  endtask

  // Reference: RISC-V M semantics via wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua;
    logic [63:0] p, xa, xb;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    xa = {32'h0, a};
    xb = {32'h0, b};
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(xb); r = p[63:32]; end
      3'd3: begin p = xa * xb; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    if (ua < 0) r = '0;
    return r;
  endfunction

  function automatic int exp_lat0(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return LAT;
  endfunction

  // Issue one op on both units, keep it held until each unit's done cycle has passed,
  // then confirm the held instruction was not accepted a second time.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_c0);
    int          c0, c1, ph0, ph1;
    logic [31:0] r0, r1;
    bit          serr0, serr1;
    c0 = -1; c1 = -1; ph0 = 0; ph1 = 0; r0 = '0; r1 = '0; serr0 = 0; serr1 = 0;
    @(negedge clk);
    set_in(1'b1, 2'b10, 7'b0000001, f3, a, b);
    for (int k = 0; k <= LAT + 4; k++) begin
      @(posedge clk);
      #1;
      if (ph0 == 1) begin b0.valid = 1'b0; ph0 = 2; end
      if (ph1 == 1) begin b1.valid = 1'b0; ph1 = 2; end
      #1;
      if (ph0 == 2) begin
        check({tag, " reaccept0"}, {62'd0, b0.stall, b0.done}, 64'd0); ph0 = 3;
      end else if (ph0 == 0) begin
        if (b0.done) begin c0 = k; r0 = b0.result; ph0 = 1; if (b0.stall) serr0 = 1; end
        else if (!b0.stall) serr0 = 1;
      end
      if (ph1 == 2) begin
        check({tag, " reaccept1"}, {62'd0, b1.stall, b1.done}, 64'd0); ph1 = 3;
      end else if (ph1 == 0) begin
        if (b1.done) begin c1 = k; r1 = b1.result; ph1 = 1; if (b1.stall) serr1 = 1; end
        else if (!b1.stall) serr1 = 1;
      end
      if (ph0 == 3 && ph1 == 3) break;
    end
    check({tag, " result0"}, 64'(r0), 64'(exp));
    check({tag, " result1"}, 64'(r1), 64'(exp));
    check({tag, " cycle0"}, 64'(c0), 64'(exp_c0));
    check({tag, " cycle1"}, 64'(c1), 64'(LAT));
    check({tag, " stall0"}, 64'(serr0), 64'd0);
    check({tag, " stall1"}, 64'(serr1), 64'd0);
    @(negedge clk);
    set_in(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    last_exp = exp;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bit          seen;

    vt[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vt[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vt[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 1'b0};
    vt[4]  = '{3'b001, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 1'b0};
    vt[5]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0};
    vt[6]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0};
    vt[7]  = '{3'b101, 32'd100,        32'd7,          32'd14,        1'b0};
    vt[8]  = '{3'b111, 32'd100,        32'd7,          32'd2,         1'b0};
    vt[9]  = '{3'b101, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 1'b1};
    vt[10] = '{3'b110, 32'h0000_1234, 32'd0,          32'h0000_1234, 1'b1};
    vt[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vt[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vt[13] = '{3'b100, 32'hFFFF_FF00, 32'd0,          32'hFFFF_FFFF, 1'b1};
    vt[14] = '{3'b111, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 1'b1};

    reset    = 1'b0;
    b0.flush = 1'b0;
    b1.flush = 1'b0;
    last_exp = '0;
    set_in(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    #12;
    check("rst done0",   64'(b0.done),   64'd0);
    check("rst result0", 64'(b0.result), 64'd0);
    check("rst stall0",  64'(b0.stall),  64'd0);
    check("rst result1", 64'(b1.result), 64'd0);
    set_in(1'b1, 2'b10, 7'h00, 3'b000, 32'h0, 32'h0);
    #1 check("dec funct7", 64'(b0.md_sel), 64'd0);
    set_in(1'b1, 2'b00, 7'h01, 3'b000, 32'h0, 32'h0);
    #1 check("dec aluop", 64'(b0.md_sel), 64'd0);
    set_in(1'b1, 2'b10, 7'h01, 3'b100, 32'h0, 32'h0);
    #1 check("dec md_sel", 64'(b0.md_sel), 64'd1);
    check("rst stall=md_sel", 64'(b0.stall), 64'd1);
    set_in(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].sp ? 1 : LAT);

    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op($sformatf("rnd%0d", i), f, a, b, model(f, a, b), exp_lat0(f, a, b));
    end

    // Flush during cycle 10 of a divide
    @(negedge clk);
    set_in(1'b1, 2'b10, 7'b0000001, 3'b100, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    b0.flush = 1'b1; b1.flush = 1'b1; b0.valid = 1'b0; b1.valid = 1'b0;
    @(posedge clk);
    #1;
    check("flush stall0",  64'(b0.stall),  64'd0);
    check("flush done0",   64'(b0.done),   64'd0);
    check("flush result0", 64'(b0.result), 64'(last_exp));
    check("flush stall1",  64'(b1.stall),  64'd0);
    check("flush result1", 64'(b1.result), 64'(last_exp));
    b0.flush = 1'b0; b1.flush = 1'b0;
    seen = 0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (b0.done || b1.done) seen = 1;
    end
    check("flush no done", 64'(seen), 64'd0);
    run_op("mul after flush", 3'b000, 32'd3, 32'd5, 32'd15, LAT);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    set_in(1'b1, 2'b10, 7'b0000001, 3'b101, 32'd1000, 32'd7);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst done0",   64'(b0.done),   64'd0);
    check("midrst result0", 64'(b0.result), 64'd0);
    check("midrst stall0",  64'(b0.stall),  64'd1);
    check("midrst result1", 64'(b1.result), 64'd0);
    check("midrst stall1",  64'(b1.stall),  64'd1);
    @(negedge clk);
    set_in(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0);
    #1;
    check("midrst idle0", 64'(b0.stall), 64'd0);
    check("midrst idle1", 64'(b1.stall), 64'd0);
    @(negedge clk) reset = 1'b1;
    run_op("divu after reset", 3'b101, 32'd9, 32'd3, 32'd3, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
